xorwow_arbiter: RTL and testbench
=================================

Name: xorwow_arbiter

Overview:
- Sequences and shares one xorwow generator among NUM_REQ requesters.
- Owns the generator's seed/re_seed inputs: performs the mandatory post-reset reseed, handles host reseed commands and discards warm-up outputs.
- Grants one 32-bit draw per cycle, round-robin over requesters with pending requests.
- Sits between the xorwow instance and the stochastic compute lanes.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DEFAULT_SEED, 32'h1234_5678, seed applied automatically after reset.
- WARMUP_CYCLES, 0, generator outputs discarded after every reseed (0..255).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_seed  in  32  seed for a host reseed; sampled when cfg_reseed=1.
- cfg_reseed  in  1  single-cycle reseed command.
- req  in  NUM_REQ  request pulses; req[i]=1 for one cycle asks for one draw.
- gnt  out  NUM_REQ  registered one-hot grant; valid together with rnd_out.
- rnd_out  out  32  registered random word for the granted requester.
- rnd_valid  out  1  equals |gnt.
- busy  out  1  high in states RESEED and WARM.
- draw_count  out  32  grants since the last reseed.
- gen_seed  out  32  to xorwow seed.
- gen_re_seed  out  1  to xorwow re_seed.
- gen_rnd  in  32  from xorwow rnd; the generator advances every clock.

Behaviour:
- Reset values: gnt=0, rnd_out=0, rnd_valid=0, draw_count=0, gen_re_seed=0, gen_seed=DEFAULT_SEED, pending=0, rr_ptr=0, warm_cnt=0, state=RESEED, busy=1.
- After reset release, the FSM reseeds automatically, because the generator resets to an all-zero stuck state.
- FSM states: RESEED, WARM, RUN.
- RESEED (exactly 1 cycle): gen_re_seed=1 and gen_seed holds the latched seed. Next state is WARM if WARMUP_CYCLES>0, else RUN. draw_count clears on this cycle's edge.
- WARM: warm_cnt counts 0..WARMUP_CYCLES-1 and outputs are discarded. Go to RUN when warm_cnt reaches WARMUP_CYCLES-1.
- RUN: stays in RUN until cfg_reseed=1.
- cfg_reseed in any state, including RESEED and WARM:
  - latch cfg_seed into gen_seed;
  - next state RESEED, and warm_cnt clears, so the sequence restarts;
  - in the same cycle, any RUN grant is suppressed.
- Request capture runs in every state: pending[i] sets on req[i]=1.
  - req[i] while pending[i] is already set is coalesced, with no error.
  - req[i] in the same cycle as its own grant re-sets pending[i], so set wins over clear.
  - Pending bits survive reseed and are served after warm-up.
- Arbitration (RUN only, no cfg_reseed): the winner is the first set pending bit at or after rr_ptr, wrapping modulo NUM_REQ. At the clock edge:
  - gnt <= onehot(winner);
  - rnd_out <= gen_rnd;
  - pending[winner] clears;
  - rr_ptr <= winner+1 (mod NUM_REQ);
  - draw_count increments and wraps at 2^32.
- No pending bits: gnt=0, rnd_valid=0, and rnd_out holds its last value.
- Throughput: at most one grant per cycle. Each gen_rnd value is delivered at most once; values produced while no requester is pending are lost.
- Latency: a req pulse at edge k with nothing else pending in RUN produces gnt at edge k+1.
- rst asserted mid-operation: all state returns to reset values immediately, and pending requests are dropped.

Decomposition:
- Shared package rng_pkg holds:
  - FSM state enum (RESEED, WARM, RUN);
  - RNG_WIDTH=32;
  - the DEFAULT_SEED constant.
- One natural sub-module: rr_arbiter (pending vector plus rr_ptr to one-hot winner and next pointer), combinational with the pointer register kept in the parent.
- The xorwow generator is instantiated alongside, not inside, this block.

Test Plan:
- Reset mid-run → busy=1 and gen_re_seed=1 with gen_seed=32'h1234_5678 in the first cycle after rst falls; gnt=0 and draw_count=0 throughout.
- cfg_reseed with cfg_seed=32'hDEAD_BEEF, WARMUP_CYCLES=0, req[0] held pulsed every cycle → consecutive rnd_out values are 1060845059, 3813551060, 3871134865, 2392425413; draw_count=4.
- Same as the previous case with cfg_seed=32'hCAFE_BABE → rnd_out values 226716488, 3993147665, 506877134; gnt=4'b0001 each time.
- All four req bits pulsed together in RUN with rr_ptr=0 → gnt sequence 0001, 0010, 0100, 1000 on 4 consecutive edges; then gnt=0 and rnd_valid=0.
- cfg_reseed asserted while the FSM is in WARM (WARMUP_CYCLES=5) → RESEED re-entered; first grant 6 cycles after the second reseed; the pending req[2] is served then with draw_count=1.
- req[1] pulsed twice before its grant, then again on its grant cycle → exactly two grants to requester 1 in total.

Source files
------------

// File: rtl/rng_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : rng_pkg
// Brief    : Shared types and constants for the xorwow arbiter slice.
// Revision : 1.0
// ---------------------------------------------------------------------------
package rng_pkg;

  localparam int RNG_WIDTH = 32;
  localparam logic [RNG_WIDTH-1:0] RNG_DEFAULT_SEED = 32'h1234_5678;

  typedef enum logic [1:0] {
    RESEED = 2'd0,
    WARM   = 2'd1,
    RUN    = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/xorwow_arbiter_rr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : rr_arbiter
// Brief    : Round-robin pick of the first pending bit at or after ptr.
// Revision : 1.0
// ---------------------------------------------------------------------------
module rr_arbiter
  import rng_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [PTR_W-1:0]   ptr,
  output logic               found,
  output logic [NUM_REQ-1:0] onehot,
  output logic [PTR_W-1:0]   next_ptr
);

  logic [PTR_W-1:0] winner;
  logic [PTR_W-1:0] cand;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = PTR_W'((int'(ptr) + off) % NUM_REQ);
      if (!found && pending[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign onehot   = found ? (NUM_REQ'(1) << winner) : '0;
  assign next_ptr = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

endmodule
`default_nettype wire

// File: rtl/xorwow_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : xorwow_arbiter
// Brief    : Sequences reseed/warm-up of one xorwow and shares its draws
//            round-robin among NUM_REQ requesters.
// Revision : 1.0
// ---------------------------------------------------------------------------
module xorwow_arbiter
  import rng_pkg::*;
#(
  parameter int                   NUM_REQ       = 4,
  parameter logic [RNG_WIDTH-1:0] DEFAULT_SEED  = RNG_DEFAULT_SEED,
  parameter int                   WARMUP_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RNG_WIDTH-1:0] cfg_seed,
  input  logic                 cfg_reseed,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [RNG_WIDTH-1:0] rnd_out,
  output logic                 rnd_valid,
  output logic                 busy,
  output logic [RNG_WIDTH-1:0] draw_count,
  output logic [RNG_WIDTH-1:0] gen_seed,
  output logic                 gen_re_seed,
  input  logic [RNG_WIDTH-1:0] gen_rnd
);

  localparam int         PTR_W     = $clog2(NUM_REQ);
  localparam logic [7:0] WARM_LAST = 8'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

  state_e               state_q, state_d;
  logic [7:0]           warm_cnt_q, warm_cnt_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [RNG_WIDTH-1:0] rnd_out_q, rnd_out_d;
  logic [RNG_WIDTH-1:0] draw_count_q, draw_count_d;
  logic [RNG_WIDTH-1:0] gen_seed_q, gen_seed_d;

  logic                 arb_found;
  logic [NUM_REQ-1:0]   arb_onehot;
  logic [PTR_W-1:0]     arb_next_ptr;
  logic                 do_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .pending  (pending_q),
    .ptr      (rr_ptr_q),
    .found    (arb_found),
    .onehot   (arb_onehot),
    .next_ptr (arb_next_ptr)
  );

  always_comb begin
    state_d      = state_q;
    warm_cnt_d   = warm_cnt_q;
    gen_seed_d   = gen_seed_q;
    rr_ptr_d     = rr_ptr_q;
    rnd_out_d    = rnd_out_q;
    draw_count_d = draw_count_q;
    do_grant     = 1'b0;

    case (state_q)
      RESEED: begin
        draw_count_d = '0;
        warm_cnt_d   = '0;
        if (WARMUP_CYCLES > 0) state_d = WARM;
        else                   state_d = RUN;
      end
      WARM: begin
        if (warm_cnt_q == WARM_LAST) begin
          state_d    = RUN;
          warm_cnt_d = '0;
        end else begin
          warm_cnt_d = warm_cnt_q + 8'd1;
        end
      end
      RUN:     do_grant = arb_found;
      default: state_d  = RESEED;
    endcase

    // A host reseed restarts the sequence from any state and pre-empts a grant.
    if (cfg_reseed) begin
      gen_seed_d = cfg_seed;
      state_d    = RESEED;
      warm_cnt_d = '0;
      do_grant   = 1'b0;
    end

    gnt_d     = do_grant ? arb_onehot : '0;
    pending_d = (pending_q & ~gnt_d) | req;

    if (do_grant) begin
      rnd_out_d    = gen_rnd;
      rr_ptr_d     = arb_next_ptr;
      draw_count_d = draw_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RESEED;
      warm_cnt_q   <= '0;
      pending_q    <= '0;
      gnt_q        <= '0;
      rr_ptr_q     <= '0;
      rnd_out_q    <= '0;
      draw_count_q <= '0;
      gen_seed_q   <= DEFAULT_SEED;
    end else begin
      state_q      <= state_d;
      warm_cnt_q   <= warm_cnt_d;
      pending_q    <= pending_d;
      gnt_q        <= gnt_d;
      rr_ptr_q     <= rr_ptr_d;
      rnd_out_q    <= rnd_out_d;
      draw_count_q <= draw_count_d;
      gen_seed_q   <= gen_seed_d;
    end
  end

  assign gnt         = gnt_q;
  assign rnd_out     = rnd_out_q;
  assign rnd_valid   = |gnt_q;
  assign busy        = (state_q != RUN);
  assign draw_count  = draw_count_q;
  assign gen_seed    = gen_seed_q;
  // Held low during reset so the generator never sees a reseed before it is released.
  assign gen_re_seed = (state_q == RESEED) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_xorwow_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_xorwow_arbiter
// Brief    : Scoreboard bench; gen_rnd is a tagged cycle count so every
//            delivered word identifies the cycle it was drawn in.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_xorwow_arbiter;

  localparam int NREQ = 4;
  localparam int WARM = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      cfg_seed = '0;
  logic             cfg_reseed = 1'b0;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  gnt;
  logic [31:0]      rnd_out;
  logic             rnd_valid;
  logic             busy;
  logic [31:0]      draw_count;
  logic [31:0]      gen_seed;
  logic             gen_re_seed;
  logic [31:0]      gen_rnd;
  logic [31:0]      cyc = '0;

  typedef struct packed {
    logic [NREQ-1:0] g;
    logic [31:0]     r;
    logic [31:0]     dc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  xorwow_arbiter #(
    .NUM_REQ       (NREQ),
    .DEFAULT_SEED  (32'h1234_5678),
    .WARMUP_CYCLES (WARM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_seed    (cfg_seed),
    .cfg_reseed  (cfg_reseed),
    .req         (req),
    .gnt         (gnt),
    .rnd_out     (rnd_out),
    .rnd_valid   (rnd_valid),
    .busy        (busy),
    .draw_count  (draw_count),
    .gen_seed    (gen_seed),
    .gen_re_seed (gen_re_seed),
    .gen_rnd     (gen_rnd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign gen_rnd = {16'hA5A5, cyc[15:0]};

  function automatic logic [31:0] rnd_at(input logic [31:0] c);
    return {16'hA5A5, c[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [31:0] c, input logic [31:0] dc);
    exp_t e;
    e.g  = g;
    e.r  = rnd_at(c);
    e.dc = dc;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every presented grant must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("valid_vs_gnt", 32'(rnd_valid), 32'(|gnt));
      if (rnd_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_grant: got gnt=%b rnd=%h expected no grant", gnt, rnd_out);
        end else begin
          e = sb.pop_front();
          check("sb_gnt", 32'(gnt), 32'(e.g));
          check("sb_rnd", rnd_out, e.r);
          check("sb_draw_count", draw_count, e.dc);
        end
      end
    end
  end

  initial begin
    logic [31:0] n;

    // Reset state
    step(3);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_valid", 32'(rnd_valid), 32'd0);
    check("rst_rnd_out", rnd_out, 32'd0);
    check("rst_draw_count", draw_count, 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_re_seed", 32'(gen_re_seed), 32'd0);
    check("rst_gen_seed", gen_seed, 32'h1234_5678);

    // Automatic post-reset reseed, then warm-up
    rst = 1'b0;
    #1;
    check("boot_re_seed", 32'(gen_re_seed), 32'd1);
    check("boot_gen_seed", gen_seed, 32'h1234_5678);
    check("boot_busy", 32'(busy), 32'd1);
    step(1);
    check("boot_re_seed_1cyc", 32'(gen_re_seed), 32'd0);
    step(4);
    check("warm_last_busy", 32'(busy), 32'd1);
    step(1);
    check("run_busy", 32'(busy), 32'd0);

    // All four requests at once from rr_ptr=0
    n = cyc;
    req = 4'b1111;
    push(4'b0001, n + 1, 32'd1);
    push(4'b0010, n + 2, 32'd2);
    push(4'b0100, n + 3, 32'd3);
    push(4'b1000, n + 4, 32'd4);
    step(1);
    req = 4'b0000;
    step(5);
    check("rr_idle_gnt", 32'(gnt), 32'd0);
    check("rr_idle_valid", 32'(rnd_valid), 32'd0);
    check("rr_hold_rnd", rnd_out, rnd_at(n + 4));
    check("rr_draw_count", draw_count, 32'd4);

    // req[1] twice before its grant and once on its grant cycle
    n = cyc;
    req = 4'b0011;
    push(4'b0001, n + 1, 32'd5);
    push(4'b0010, n + 2, 32'd6);
    push(4'b0010, n + 3, 32'd7);
    step(1);
    req = 4'b0010;
    step(1);
    req = 4'b0010;
    step(1);
    req = 4'b0000;
    step(3);
    check("coalesce_draw_count", draw_count, 32'd7);

    // Reseed in RUN suppresses a pending grant; reseed again while in WARM
    req = 4'b0100;
    step(1);
    req = 4'b0000;
    cfg_reseed = 1'b1;
    cfg_seed = 32'hDEAD_BEEF;
    step(1);
    cfg_reseed = 1'b0;
    check("reseed1_re_seed", 32'(gen_re_seed), 32'd1);
    check("reseed1_gen_seed", gen_seed, 32'hDEAD_BEEF);
    check("reseed1_busy", 32'(busy), 32'd1);
    check("reseed1_dc_before_clear", draw_count, 32'd7);
    step(1);
    check("reseed1_dc_cleared", draw_count, 32'd0);
    check("reseed1_re_seed_drop", 32'(gen_re_seed), 32'd0);
    step(1);
    cfg_reseed = 1'b1;
    cfg_seed = 32'hCAFE_BABE;
    step(1);
    cfg_reseed = 1'b0;
    check("reseed2_re_seed", 32'(gen_re_seed), 32'd1);
    check("reseed2_gen_seed", gen_seed, 32'hCAFE_BABE);
    n = cyc;
    push(4'b0100, n + 6, 32'd1);
    step(5);
    check("reseed2_warm_busy", 32'(busy), 32'd1);
    step(1);
    check("reseed2_run_busy", 32'(busy), 32'd0);
    step(3);
    check("reseed2_draw_count", draw_count, 32'd1);

    // Reset mid-run drops pending requests and rr_ptr
    req = 4'b0011;
    step(1);
    req = 4'b0000;
    rst = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_draw_count", draw_count, 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_gen_seed", gen_seed, 32'h1234_5678);
    step(2);
    rst = 1'b0;
    #1;
    check("midrst_boot_re_seed", 32'(gen_re_seed), 32'd1);
    check("midrst_boot_gen_seed", gen_seed, 32'h1234_5678);
    step(8);
    check("midrst_no_grants", draw_count, 32'd0);
    check("midrst_rnd_out", rnd_out, 32'd0);

    n = cyc;
    req = 4'b1010;
    push(4'b0010, n + 1, 32'd1);
    push(4'b1000, n + 2, 32'd2);
    step(1);
    req = 4'b0000;
    step(4);
    check("post_rst_draw_count", draw_count, 32'd2);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
